// File: rtl/pll_reset_supervisor.sv
// pll_reset_supervisor: drives PLL reset, qualifies lock with timeout/retries,
// releases staggered domain resets and re-sequences on lock loss.
module pll_reset_supervisor #(
    parameter int N_OUT          = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER        = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pll_locked,
    input  logic             i_soft_rst,
    output logic             o_pll_rst,
    output logic [N_OUT-1:0] o_rst_out,
    output logic             o_ready,
    output logic             o_fault,
    output logic [7:0]       o_retry_cnt
);
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    localparam int REL_SPAN = STAGGER * (N_OUT - 1);
    localparam int MAXV     = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT), max2(STABLE_CYCLES, REL_SPAN));
    localparam int CW       = $clog2(MAXV + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN, S_FAULT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [1:0]       r_sync;
    logic             w_lock_s;
    logic [7:0]       r_retry, w_retry_nxt;
    logic             r_pll_rst, r_ready, r_fault;
    logic [N_OUT-1:0] r_rst_out, w_rst_out_nxt;

    assign w_lock_s    = r_sync[1];
    assign o_pll_rst   = r_pll_rst;
    assign o_rst_out   = r_rst_out;
    assign o_ready     = r_ready;
    assign o_fault     = r_fault;
    assign o_retry_cnt = r_retry;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_retry_nxt = r_retry;
        if (i_soft_rst) begin
            w_state_nxt = S_RESET_PLL;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                S_RESET_PLL:
                    if (r_cnt == CW'(PLL_RST_CYCLES - 1)) w_state_nxt = S_WAIT_LOCK;
                    else w_cnt_nxt = r_cnt + 1'b1;
                S_WAIT_LOCK:
                    if (w_lock_s) w_state_nxt = S_STABLE;
                    else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        if (r_retry < 8'(MAX_RETRIES)) begin
                            w_retry_nxt = r_retry + 8'd1;
                            w_state_nxt = S_RESET_PLL;
                        end else w_state_nxt = S_FAULT;
                    end else w_cnt_nxt = r_cnt + 1'b1;
                S_STABLE:
                    if (!w_lock_s) w_state_nxt = S_WAIT_LOCK;
                    else if (r_cnt == CW'(STABLE_CYCLES - 1)) w_state_nxt = (N_OUT == 1) ? S_RUN : S_RELEASE;
                    else w_cnt_nxt = r_cnt + 1'b1;
                S_RELEASE:
                    if (!w_lock_s) w_state_nxt = S_RESET_PLL;
                    else begin
                        // counter holds cycles elapsed since RST_OUT[0] fell
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (w_cnt_nxt == CW'(REL_SPAN)) w_state_nxt = S_RUN;
                    end
                S_RUN:
                    if (!w_lock_s) w_state_nxt = S_RESET_PLL;
                default: ;
            endcase
        end
        if (w_state_nxt == S_RUN) w_retry_nxt = '0;
        w_rst_out_nxt = '1;
        for (int i = 0; i < N_OUT; i++)
            w_rst_out_nxt[i] = (w_state_nxt == S_RUN) ? 1'b0 :
                               (w_state_nxt == S_RELEASE) ? (w_cnt_nxt < CW'(STAGGER * i)) : 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_RESET_PLL;
            r_cnt     <= '0;
            r_sync    <= '0;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sync    <= {r_sync[0], i_pll_locked};
            r_retry   <= w_retry_nxt;
            r_pll_rst <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
            r_rst_out <= w_rst_out_nxt;
            r_ready   <= w_state_nxt == S_RUN;
            r_fault   <= w_state_nxt == S_FAULT;
        end
    end
endmodule

// File: tb/tb_pll_reset_supervisor.sv
// tb_pll_reset_supervisor: directed checks of lock sequencing, retries, fault,
// soft reset, lock loss and staggered release on three parameterisations.
module tb_pll_reset_supervisor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_locked, a_soft, a_pll_rst, a_ready, a_fault;
    logic [1:0] a_rst_out;
    logic [7:0] a_retry;
    logic       b_rst_n, b_locked, b_soft, b_pll_rst, b_ready, b_fault;
    logic [3:0] b_rst_out;
    logic [7:0] b_retry;
    logic       c_rst_n, c_locked, c_soft, c_pll_rst, c_ready, c_fault;
    logic [0:0] c_rst_out;
    logic [7:0] c_retry;

    int n_checks = 0;
    int n_errors = 0;

    pll_reset_supervisor #(.LOCK_TIMEOUT(100)) u_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_pll_locked(a_locked), .i_soft_rst(a_soft),
        .o_pll_rst(a_pll_rst), .o_rst_out(a_rst_out), .o_ready(a_ready),
        .o_fault(a_fault), .o_retry_cnt(a_retry)
    );

    pll_reset_supervisor #(.N_OUT(4), .STAGGER(3), .STABLE_CYCLES(20), .LOCK_TIMEOUT(100),
                           .MAX_RETRIES(0)) u_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_pll_locked(b_locked), .i_soft_rst(b_soft),
        .o_pll_rst(b_pll_rst), .o_rst_out(b_rst_out), .o_ready(b_ready),
        .o_fault(b_fault), .o_retry_cnt(b_retry)
    );

    pll_reset_supervisor #(.N_OUT(1), .PLL_RST_CYCLES(2), .STABLE_CYCLES(4),
                           .LOCK_TIMEOUT(100)) u_c (
        .i_clk(clk), .i_rst_n(c_rst_n), .i_pll_locked(c_locked), .i_soft_rst(c_soft),
        .o_pll_rst(c_pll_rst), .o_rst_out(c_rst_out), .o_ready(c_ready),
        .o_fault(c_fault), .o_retry_cnt(c_retry)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        a_rst_n = 0; a_locked = 1; a_soft = 0;
        b_rst_n = 0; b_locked = 1; b_soft = 0;
        c_rst_n = 0; c_locked = 1; c_soft = 0;
        tick(3);
        check("a_rst_pll_rst", a_pll_rst, 1);
        check("a_rst_rst_out", a_rst_out, 2'b11);
        check("a_rst_ready", a_ready, 0);
        check("a_rst_fault", a_fault, 0);
        check("a_rst_retry", a_retry, 0);

        // power-up sequence with lock held
        a_rst_n = 1;
        tick(15);   check("a_pll_rst_hold", a_pll_rst, 1);
        tick(1);    check("a_pll_rst_drop", a_pll_rst, 0);
        tick(1024); check("a_pre_release", a_rst_out, 2'b11);
        tick(1);    check("a_release0", a_rst_out, 2'b10);
        tick(7);    check("a_stagger_hold", a_rst_out, 2'b10);
                    check("a_ready_early", a_ready, 0);
        tick(1);    check("a_release1", a_rst_out, 2'b00);
                    check("a_ready", a_ready, 1);
                    check("a_retry_run", a_retry, 0);

        // lock loss in RUN
        a_locked = 0;
        tick(2);    check("a_loss_latency", a_ready, 1);
        tick(1);    check("a_loss_rst_out", a_rst_out, 2'b11);
                    check("a_loss_ready", a_ready, 0);
                    check("a_loss_pll_rst", a_pll_rst, 1);
                    check("a_loss_retry", a_retry, 0);
        a_locked = 1;
        tick(15);   check("a_reseq_pll_hold", a_pll_rst, 1);
        tick(1);    check("a_reseq_pll_drop", a_pll_rst, 0);
        tick(1032); check("a_reseq_not_ready", a_ready, 0);
        tick(1);    check("a_reseq_ready", a_ready, 1);
                    check("a_reseq_rst_out", a_rst_out, 2'b00);

        // held soft reset, then a one-cycle lock glitch at stable count 500
        a_soft = 1;
        tick(30);   check("a_soft_pll_rst", a_pll_rst, 1);
                    check("a_soft_ready", a_ready, 0);
                    check("a_soft_rst_out", a_rst_out, 2'b11);
        a_soft = 0;
        tick(15);   check("a_soft_cnt_held", a_pll_rst, 1);
        tick(1);    check("a_soft_pll_drop", a_pll_rst, 0);
        tick(501);
        a_locked = 0;
        tick(1);
        a_locked = 1;
        tick(523);  check("a_glitch_no_release", a_rst_out, 2'b11);
        tick(503);  check("a_glitch_pre_release", a_rst_out, 2'b11);
                    check("a_glitch_retry", a_retry, 0);
        tick(1);    check("a_glitch_release", a_rst_out, 2'b10);

        // no lock: retries then FAULT
        a_locked = 0; a_soft = 1;
        tick(1);    check("a_nolock_retry0", a_retry, 0);
        a_soft = 0;
        tick(16);   check("a_try1_pll_drop", a_pll_rst, 0);
        tick(99);   check("a_try1_pre_timeout", a_retry, 0);
                    check("a_try1_pll_low", a_pll_rst, 0);
        tick(1);    check("a_retry1", a_retry, 1);
                    check("a_try2_pll_rst", a_pll_rst, 1);
        tick(16);   check("a_try2_pll_drop", a_pll_rst, 0);
        tick(100);  check("a_retry2", a_retry, 2);
        tick(116);  check("a_retry3", a_retry, 3);
        tick(115);  check("a_pre_fault", a_fault, 0);
        tick(1);    check("a_fault", a_fault, 1);
                    check("a_fault_pll_rst", a_pll_rst, 1);
                    check("a_fault_rst_out", a_rst_out, 2'b11);
                    check("a_fault_retry", a_retry, 3);
        a_locked = 1;
        tick(50);   check("a_fault_sticky", a_fault, 1);
                    check("a_fault_sticky_ready", a_ready, 0);
        a_soft = 1;
        tick(1);    check("a_fault_clear", a_fault, 0);
                    check("a_fault_clear_retry", a_retry, 0);
                    check("a_fault_clear_pll", a_pll_rst, 1);
        a_soft = 0;
        tick(1048); check("a_after_fault_not_ready", a_ready, 0);
        tick(1);    check("a_after_fault_ready", a_ready, 1);
                    check("a_after_fault_rst_out", a_rst_out, 2'b00);

        // four outputs, stagger 3
        b_rst_n = 1;
        tick(36);   check("b_pre_release", b_rst_out, 4'hF);
        tick(1);    check("b_off0", b_rst_out, 4'b1110);
        tick(2);    check("b_off2", b_rst_out, 4'b1110);
        tick(1);    check("b_off3", b_rst_out, 4'b1100);
        tick(3);    check("b_off6", b_rst_out, 4'b1000);
        tick(2);    check("b_off8_ready", b_ready, 0);
        tick(1);    check("b_off9", b_rst_out, 4'b0000);
                    check("b_ready", b_ready, 1);

        // async reset mid-RELEASE
        b_rst_n = 0;
        tick(1);
        b_rst_n = 1;
        tick(41);   check("b_mid_release", b_rst_out, 4'b1100);
        #2 b_rst_n = 0;
        #1;
        check("b_async_rst_out", b_rst_out, 4'hF);
        check("b_async_pll_rst", b_pll_rst, 1);
        check("b_async_ready", b_ready, 0);
        check("b_async_fault", b_fault, 0);

        // MAX_RETRIES=0: first timeout faults
        b_locked = 0;
        tick(2);
        b_rst_n = 1;
        tick(115);  check("b_pre_fault", b_fault, 0);
                    check("b_pre_fault_pll", b_pll_rst, 0);
        tick(1);    check("b_fault", b_fault, 1);
                    check("b_fault_retry", b_retry, 0);
                    check("b_fault_pll", b_pll_rst, 1);

        // single output: RST_OUT[0] and READY change together
        c_rst_n = 1;
        tick(6);    check("c_pre_rst_out", c_rst_out, 1);
                    check("c_pre_ready", c_ready, 0);
        tick(1);    check("c_rst_out", c_rst_out, 0);
                    check("c_ready", c_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pll_reset_supervisor.md
Name: pll_reset_supervisor

Overview:
Parametrised clock-lock supervisor that sits beside the board PLL, clocked from the free-running input reference after the global input buffer. It drives the PLL reset and waits for lock, with a timeout and a bounded number of retries. It then qualifies lock stability and releases N downstream domain resets in a staggered order. It also detects lock loss during operation and re-sequences automatically, a capability the previous clock block lacked because it tied LOCKED off and never sequenced resets.

Parameters:
N_OUT, 2, number of downstream reset outputs (1..16)
PLL_RST_CYCLES, 16, cycles PLL_RST is held high per attempt (>=1)
LOCK_TIMEOUT, 65535, max cycles in WAIT_LOCK before an attempt fails (>=1)
STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (>=1)
STAGGER, 8, cycles between successive RST_OUT releases (>=1)
MAX_RETRIES, 3, failed attempts allowed before FAULT (0..255)

Ports:
CLK  in  1  free-running reference clock
RST_N  in  1  asynchronous active-low reset
PLL_LOCKED  in  1  PLL lock, asynchronous to CLK
SOFT_RST  in  1  synchronous request, 1-cycle pulse or level, restarts sequencing
PLL_RST  out  1  active-high reset to PLL
RST_OUT  out  N_OUT  active-high domain resets, bit 0 released first
READY  out  1  all domains released, lock good
FAULT  out  1  retries exhausted
RETRY_CNT  out  8  failed attempts since last clean start

Behaviour:
- Reset (RST_N=0, async): state RESET_PLL, PLL_RST=1, RST_OUT=all 1, READY=0, FAULT=0, RETRY_CNT=0. All counters cleared.
- PLL_LOCKED passes through a 2-FF synchroniser, giving lock_s, with 2 cycles of latency. The FSM uses only lock_s.
- All outputs are registered. Counters are sized with $clog2(param+1).
- RESET_PLL:
  - PLL_RST=1, RST_OUT all 1.
  - After exactly PLL_RST_CYCLES rising edges in this state, go to WAIT_LOCK. PLL_RST=0 from that edge.
- WAIT_LOCK:
  - lock_s=1 -> STABLE.
  - Timeout counter reaches LOCK_TIMEOUT with lock_s still 0 -> attempt failed.
  - On failure: if RETRY_CNT<MAX_RETRIES, increment RETRY_CNT and go to RESET_PLL.
  - Otherwise go to FAULT (RETRY_CNT unchanged).
- STABLE:
  - Counts consecutive lock_s=1 cycles.
  - Any lock_s=0 -> back to WAIT_LOCK with a fresh timeout count. RETRY_CNT is not incremented.
  - Count reaches STABLE_CYCLES -> RELEASE.
- RELEASE:
  - RST_OUT[0] deasserts on the entry edge.
  - RST_OUT[i] deasserts STAGGER*i cycles after RST_OUT[0].
  - When RST_OUT[N_OUT-1] deasserts, go to RUN. READY=1 on the same edge.
- RUN: READY=1, RST_OUT=0, RETRY_CNT cleared to 0 on entry.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - Next edge: RST_OUT all 1, READY=0, state RESET_PLL, PLL_RST=1.
  - RETRY_CNT is not incremented.
- FAULT:
  - PLL_RST=1, RST_OUT all 1, READY=0, FAULT=1.
  - Ignores PLL_LOCKED.
  - Exits only via RST_N or SOFT_RST.
- SOFT_RST=1 in any state:
  - Next edge: RESET_PLL, RETRY_CNT=0, FAULT=0, READY=0, RST_OUT all 1, PLL_RST=1, counters cleared.
  - A held level keeps the block in RESET_PLL with the count held at 0.
- Priority within a cycle: RST_N > SOFT_RST > lock loss > timeout/count completion.
- MAX_RETRIES=0: the first timeout goes directly to FAULT.
- N_OUT=1: RELEASE lasts one edge, and RST_OUT[0] and READY change together.
- RST_OUT deassertion is synchronous to CLK. Consumers in other clock domains re-synchronise it themselves.

Test Plan:
- Reset release, PLL_LOCKED=1 constant, defaults:
  - PLL_RST high for 16 cycles.
  - RST_OUT[0] falls 16+2+1024 (+/-1 for sync) cycles after reset release.
  - RST_OUT[1] falls 8 cycles after RST_OUT[0], READY rises with it, RETRY_CNT=0.
- PLL_LOCKED=0 forever, LOCK_TIMEOUT=100, MAX_RETRIES=3:
  - Four PLL_RST pulses of 16 cycles each.
  - RETRY_CNT steps 1,2,3.
  - FAULT=1 after the 4th timeout, with PLL_RST=1 and RST_OUT=2'b11 held.
- Lock glitch low for 1 cycle at STABLE count 500:
  - Returns to WAIT_LOCK, no RETRY_CNT change.
  - Release occurs 1024 cycles after the lock returns.
- In RUN, drop PLL_LOCKED:
  - Within 3 cycles, RST_OUT=all 1, READY=0, PLL_RST=1.
  - Full resequence follows and READY returns.
- In FAULT, pulse SOFT_RST with PLL_LOCKED=1:
  - FAULT=0 and RETRY_CNT=0 next edge.
  - Normal release sequence follows.
- N_OUT=4, STAGGER=3: RST_OUT bits fall at offsets 0,3,6,9 from the first release. Assert RST_N low mid-RELEASE: all outputs return to reset values immediately (asynchronously).
